// File: rtl/mem_load_unit_pkg.sv
// mips_load_pkg: shared load types, register-file write codes, FSM states and request decode helpers
package mips_load_pkg;
   typedef enum logic [2:0] {LB, LBU, LH, LHU, LW, LWL, LWR, LT_ILL} load_type_t;
   typedef enum logic [1:0] {IDLE, READ, WB, ERR} state_t;
   localparam logic [1:0] REGW_NONE = 2'b00;
   localparam logic [1:0] REGW_LWL  = 2'b01;
   localparam logic [1:0] REGW_LWR  = 2'b10;
   localparam logic [1:0] REGW_FULL = 2'b11;
   function automatic logic is_illegal(load_type_t t, logic [1:0] a);
      return ((t == LH || t == LHU) && a[0]) || (t == LW && a != 2'b00) || t == LT_ILL;
   endfunction
   function automatic logic [3:0] byte_en(load_type_t t, logic [1:0] a);
      return (t == LB || t == LBU) ? 4'b0001 << a :
             (t == LH || t == LHU) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction
endpackage

// File: rtl/mem_load_unit_if.sv
// mem_load_unit_if: Avalon-style read-only data bus between the load unit and memory
interface mem_load_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic [ADDR_W-1:0]   avm_address;
   logic                avm_read;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_waitrequest;
   logic [DATA_W-1:0]   avm_readdata;
   modport master (output avm_address, avm_read, avm_byteenable, input avm_waitrequest, avm_readdata);
   modport slave (input avm_address, avm_read, avm_byteenable, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/mem_load_unit_extract.sv
// load_extract: lane select and sign/zero extension of a read word, plus the register-file write code
module load_extract
   import mips_load_pkg::*;
(
   input  load_type_t  load_type,
   input  logic [1:0]  lsb,
   input  logic [31:0] readdata,
   output logic [31:0] write_data,
   output logic [1:0]  reg_write
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   always_comb begin
      byte_v = readdata[{lsb, 3'b000} +: 8];
      half_v = lsb[1] ? readdata[31:16] : readdata[15:0];
      write_data = load_type == LB  ? {{24{byte_v[7]}}, byte_v} :
                   load_type == LBU ? {24'd0, byte_v} :
                   load_type == LH  ? {{16{half_v[15]}}, half_v} :
                   load_type == LHU ? {16'd0, half_v} : readdata;
      reg_write  = load_type == LWL ? REGW_LWL : load_type == LWR ? REGW_LWR : REGW_FULL;
   end
endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: multi-cycle MIPS load stage, bus read then one-cycle register-file write-back
module mem_load_unit
   import mips_load_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        load_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [4:0]        dest_reg,
   mem_load_unit_if.master   bus,
   output logic              busy,
   output logic              done,
   output logic              addr_error,
   output logic [1:0]        RegWrite,
   output logic [4:0]        WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic [1:0]        data_address2LSB
);
   state_t            state, state_n;
   load_type_t        lt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [4:0]        dst_q;
   logic [31:0]       wd_q, wd_n;
   logic [1:0]        rw_q, rw_n;
   logic              accept, handshake;
   load_extract ex (.load_type(lt_q), .lsb(addr_q[1:0]), .readdata(bus.avm_readdata), .write_data(wd_n), .reg_write(rw_n));
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      accept    = state == IDLE && start;
      handshake = state == READ && !bus.avm_waitrequest;
      state_n   = accept ? (is_illegal(load_type_t'(load_type), addr[1:0]) ? ERR : READ) :
                  state == READ ? (handshake ? WB : READ) : IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         lt_q   <= LB;
         addr_q <= '0;
         dst_q  <= '0;
         wd_q   <= '0;
         rw_q   <= REGW_NONE;
      end else begin
         if (accept) begin
            lt_q   <= load_type_t'(load_type);
            addr_q <= addr;
            dst_q  <= dest_reg;
         end
         if (handshake) begin
            wd_q <= wd_n;
            rw_q <= dst_q == 5'd0 ? REGW_NONE : rw_n;
         end
      end
   // Outputs decode straight from flops, so reset clears them without waiting for an edge
   assign bus.avm_read       = state == READ;
   assign bus.avm_address    = bus.avm_read ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.avm_byteenable = bus.avm_read ? byte_en(lt_q, addr_q[1:0]) : 4'b0000;
   assign busy               = state != IDLE;
   assign done               = state == WB;
   assign addr_error         = state == ERR;
   assign RegWrite           = done ? rw_q : REGW_NONE;
   assign WriteReg           = done ? dst_q : 5'd0;
   assign WriteData          = done ? wd_q : '0;
   assign data_address2LSB   = done ? addr_q[1:0] : 2'b00;
endmodule
